// File: rtl/lsu_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the RV32I load/store memory controller:
//   funct3 encodings, controller state type, latency counter width and
//   small decode helpers used by the controller.
// ---------------------------------------------------------------------------
package lsu_pkg;

    // RV32I load/store funct3 encodings (stores reuse B/H/W).
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Wide enough for latencies 1..7.
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return ((f3[1:0] == 2'b01) && lane[0]) ||
               ((f3[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
//   Request/response bundle between the datapath memory stage (master) and
//   the memory controller (slave).
//   req_valid/req_ready : request handshake, accepted when both high
//   req_we, req_funct3  : store flag and RV32I access type
//   req_addr, req_wdata : byte address and LSB-aligned store data
//   rsp_valid           : one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err  : extended load data and fault flag, held between responses
//   busy                : transaction in flight
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/lsu_mem_ctrl_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational load formatter: selects the byte/halfword addressed by the
//   lane bits out of a 32-bit storage word and sign- or zero-extends it.
//   i_word   : storage word
//   i_lane   : byte address bits [1:0]
//   i_funct3 : RV32I load funct3
//   o_rdata  : extended result (0 for an unknown funct3)
// ---------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_lane +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        // NOTE: default assignment first so every path drives o_rdata and no latch is inferred.
        o_rdata = 32'd0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            F3_W:    o_rdata = i_word;
            default: o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   RV32I data-memory controller. Accepts one load/store per handshake,
//   responds after READ_LAT / WRITE_LAT cycles and flags misaligned,
//   out-of-range or illegal accesses.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : lsu_mem_ctrl_if slave port (request handshake, response, busy)
// ---------------------------------------------------------------------------
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 1,
    parameter int WRITE_LAT   = 1
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-3:0] DEPTH_LIMIT = (ADDR_W-2)'(DEPTH_WORDS);

    // Controller state and registered outputs.
    state_t                 r_state;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [31:0]            r_rsp_rdata;

    // Latched request.
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [ADDR_W-1:0]      r_addr;
    logic [31:0]            r_wdata;

    logic [31:0]            r_mem [DEPTH_WORDS];

    logic                   w_accept;
    logic                   w_idle;
    logic                   w_cur_we;
    logic [2:0]             w_cur_funct3;
    logic [ADDR_W-1:0]      w_cur_addr;
    logic [31:0]            w_cur_wdata;
    logic [LAT_CNT_W-1:0]   w_lat;
    logic                   w_to_resp;
    logic [ADDR_W-3:0]      w_idx;
    logic [IDX_W-1:0]       w_mem_idx;
    logic                   w_err;
    logic [31:0]            w_rd_word;
    logic [31:0]            w_ext;

    assign w_accept = bus.req_valid && r_ready;
    assign w_idle   = (r_state == IDLE);

    // With a latency of 1 the RESP-entry edge is the acceptance edge itself,
    // so the access must use the live request rather than the latch.
    assign w_cur_we     = w_idle ? bus.req_we     : r_we;
    assign w_cur_funct3 = w_idle ? bus.req_funct3 : r_funct3;
    assign w_cur_addr   = w_idle ? bus.req_addr   : r_addr;
    assign w_cur_wdata  = w_idle ? bus.req_wdata  : r_wdata;

    assign w_lat = w_cur_we ? LAT_CNT_W'(WRITE_LAT) : LAT_CNT_W'(READ_LAT);

    // WAIT is loaded with LAT-1 and leaves on the cycle the count reaches 1,
    // which puts RESP exactly LAT cycles after acceptance.
    assign w_to_resp = w_idle ? (w_accept && (w_lat == LAT_CNT_W'(1)))
                              : ((r_state == WAIT) && (r_cnt == LAT_CNT_W'(1)));

    assign w_idx     = w_cur_addr[ADDR_W-1:2];
    assign w_mem_idx = w_idx[IDX_W-1:0];
    assign w_err     = !funct3_legal(w_cur_we, w_cur_funct3) ||
                       is_misaligned(w_cur_funct3, w_cur_addr[1:0]) ||
                       (w_idx >= DEPTH_LIMIT);

    assign w_rd_word = r_mem[w_mem_idx];

    load_extend u_load_extend (
        .i_word   (w_rd_word),
        .i_lane   (w_cur_addr[1:0]),
        .i_funct3 (w_cur_funct3),
        .o_rdata  (w_ext)
    );

    assign bus.req_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_to_resp) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= w_lat - LAT_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (w_to_resp) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - LAT_CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            // Response data is only updated here and held until the next response.
            if (w_to_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_cur_we || w_err) ? 32'd0 : w_ext;
            end
        end
    end

    // Request latch: pure datapath, only read while the FSM is out of IDLE.
    always_ff @(posedge clk) begin
        if (w_idle && w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
        end
    end

    // Storage array with byte-lane writes on the RESP-entry edge.
    // NOTE: the array has no reset; contents survive rst and clearing it would need a per-word loop in hardware.
    always_ff @(posedge clk) begin
        if (!rst && w_to_resp && w_cur_we && !w_err) begin
            case (w_cur_funct3[1:0])
                2'b00:   r_mem[w_mem_idx][8*w_cur_addr[1:0] +: 8] <= w_cur_wdata[7:0];
                2'b01:   r_mem[w_mem_idx][16*w_cur_addr[1] +: 16] <= w_cur_wdata[15:0];
                default: r_mem[w_mem_idx]                         <= w_cur_wdata;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Self-checking bench: two controllers (latency 1/1 and 3/4) driven with
//   directed and random loads/stores, compared against a byte-array model.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 256;
    localparam int RL0 = 1, WL0 = 1;
    localparam int RL1 = 3, WL1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus0 ();
    lsu_mem_ctrl_if #(.ADDR_W(32)) bus1 ();

    lsu_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(RL0), .WRITE_LAT(WL0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    lsu_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(RL1), .WRITE_LAT(WL1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Byte-addressed reference memory, one per controller.
    logic [7:0] mdl [2][DEPTH*4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if ((a / 4) >= DEPTH) return 1'b1;
        if (we && (f3 > 3'd2)) return 1'b1;
        if (!we && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7))) return 1'b1;
        size = 1 << (f3 % 4);
        if ((a % size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input int d, input logic [2:0] f3, input logic [31:0] a);
        longint v = 0;
        int     n = 1 << (f3 % 4);
        for (int k = 0; k < n; k++) v = v + (longint'(mdl[d][a + k]) << (8 * k));
        if ((f3 == 3'd0) && (v >= 128))   v = v - 256;
        if ((f3 == 3'd1) && (v >= 32768)) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic mdl_store(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int n = 1 << (f3 % 4);
        for (int k = 0; k < n; k++) mdl[d][a + k] = w[8*k +: 8];
    endtask

    task automatic drive(input int d, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = a; bus0.req_wdata = w;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
            bus1.req_addr = a; bus1.req_wdata = w;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic get_rsp(input int d, output logic v, output logic [31:0] rd, output logic er);
        if (d == 0) begin v = bus0.rsp_valid; rd = bus0.rsp_rdata; er = bus0.rsp_err; end
        else        begin v = bus1.rsp_valid; rd = bus1.rsp_rdata; er = bus1.rsp_err; end
    endtask

    // One transaction: handshake, latency/response checks, model update.
    // Called and returns just after a falling edge.
    task automatic do_txn(input int d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, output logic [31:0] rd_o);
        int          lat, lat_obs, rdy_hi, busy_lo, n;
        bit          junk;
        logic        v, er, e;
        logic [31:0] rd, exp_rd;

        lat    = (d == 0) ? (we ? WL0 : RL0) : (we ? WL1 : RL1);
        e      = exp_err(we, f3, a);
        exp_rd = (we || e) ? 32'd0 : mdl_load(d, f3, a);
        junk   = bit'($urandom_range(0, 1));

        n = 0;
        while (!get_ready(d) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("rdy_wait d%0d", d), 32'(get_ready(d)), 32'd1);

        drive(d, 1'b1, we, f3, a, w);
        @(negedge clk);
        // A competing store offered while busy must be ignored.
        if (junk) drive(d, 1'b1, 1'b1, F3_W, 32'($urandom_range(0, 15)) * 4, $urandom);
        else      drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        lat_obs = 0; rdy_hi = 0; busy_lo = 0;
        v = 1'b0; rd = 32'd0; er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            get_rsp(d, v, rd, er);
            if (get_ready(d)) rdy_hi++;
            if (!get_busy(d)) busy_lo++;
            if (v) begin
                lat_obs = c;
                break;
            end
            @(negedge clk);
        end
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        check($sformatf("lat d%0d we%0d", d, we), 32'(lat_obs), 32'(lat));
        check($sformatf("rdy_low d%0d", d), 32'(rdy_hi), 32'd0);
        check($sformatf("busy_hi d%0d", d), 32'(busy_lo), 32'd0);
        check($sformatf("rdata d%0d f3=%0d a=%h", d, f3, a), rd, exp_rd);
        check($sformatf("err d%0d f3=%0d a=%h", d, f3, a), 32'(er), 32'(e));
        rd_o = rd;

        @(negedge clk);
        get_rsp(d, v, rd, er);
        check($sformatf("vld_pulse d%0d", d), 32'(v), 32'd0);
        check($sformatf("rdy_back d%0d", d), 32'(get_ready(d)), 32'd1);
        check($sformatf("rd_hold d%0d", d), rd, exp_rd);

        if (we && !e) mdl_store(d, f3, a, w);
    endtask

    initial begin
        logic [31:0] rd;
        logic        v, er;
        int          pulses;

        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of both controllers.
        for (int d = 0; d < 2; d++) begin
            get_rsp(d, v, rd, er);
            check($sformatf("rst_ready d%0d", d), 32'(get_ready(d)), 32'd1);
            check($sformatf("rst_busy d%0d", d), 32'(get_busy(d)), 32'd0);
            check($sformatf("rst_valid d%0d", d), 32'(v), 32'd0);
            check($sformatf("rst_rdata d%0d", d), rd, 32'd0);
            check($sformatf("rst_err d%0d", d), 32'(er), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Give the region under test known contents.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) do_txn(d, 1'b1, F3_W, 32'(i * 4), $urandom, rd);

        // Directed vectors on the 1/1 controller.
        do_txn(0, 1'b1, F3_W, 32'h08, 32'h8000_00FF, rd);
        do_txn(0, 1'b0, F3_W, 32'h08, 32'd0, rd);   check("lw_08", rd, 32'h8000_00FF);
        do_txn(0, 1'b0, F3_B, 32'h08, 32'd0, rd);   check("lb_08", rd, 32'hFFFF_FFFF);
        do_txn(0, 1'b0, F3_BU, 32'h08, 32'd0, rd);  check("lbu_08", rd, 32'h0000_00FF);
        do_txn(0, 1'b0, F3_H, 32'h0A, 32'd0, rd);   check("lh_0a", rd, 32'hFFFF_8000);
        do_txn(0, 1'b1, F3_W, 32'h0C, 32'h1122_3344, rd);
        do_txn(0, 1'b1, F3_B, 32'h0D, 32'h0000_00AB, rd);
        do_txn(0, 1'b0, F3_W, 32'h0C, 32'd0, rd);   check("sb_merge", rd, 32'h1122_AB44);

        // Faulting accesses, followed by readback of the touched word.
        do_txn(0, 1'b1, F3_H, 32'h11, 32'h0000_BEEF, rd);
        do_txn(0, 1'b0, F3_W, 32'h10, 32'd0, rd);
        do_txn(0, 1'b0, F3_W, 32'h12, 32'd0, rd);
        do_txn(0, 1'b0, F3_W, 32'(DEPTH * 4), 32'd0, rd);
        do_txn(0, 1'b1, F3_W, 32'(DEPTH * 4), 32'hFFFF_FFFF, rd);
        do_txn(0, 1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, rd);
        do_txn(0, 1'b0, 3'd3, 32'h10, 32'd0, rd);
        do_txn(0, 1'b0, F3_W, 32'h10, 32'd0, rd);

        // Longer latencies on the 3/4 controller.
        do_txn(1, 1'b1, F3_W, 32'h08, 32'h8000_00FF, rd);
        do_txn(1, 1'b0, F3_W, 32'h08, 32'd0, rd);   check("lw_08_lat3", rd, 32'h8000_00FF);

        // Reset during the WAIT phase of a store.
        drive(1, 1'b1, 1'b1, F3_W, 32'h14, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 32'(get_ready(1)), 32'd1);
        check("rst_mid_busy", 32'(get_busy(1)), 32'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            get_rsp(1, v, rd, er);
            if (v) pulses++;
            @(negedge clk);
        end
        check("rst_mid_pulses", 32'(pulses), 32'd0);
        do_txn(1, 1'b0, F3_W, 32'h14, 32'd0, rd);

        // Random mix against the model.
        for (int i = 0; i < 200; i++) begin
            int          d;
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            d  = int'($urandom_range(0, 1));
            we = bit'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0400;
            else                           a = 32'($urandom_range(0, 63));
            do_txn(d, we, f3, a, $urandom, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
